// File: rtl/ghost_pkg.sv
// ghost_pkg: shared mode codes and axis step/clamp helpers for the ghost controller.
package ghost_pkg;
  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] HOME = 2'd0, CHASE = 2'd1, FRIGHT = 2'd2, SCATTER = 2'd3;
  localparam int CW = 16;
  function automatic logic [CW-1:0] clamp(input logic signed [CW:0] v, input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    return (v < $signed({1'b0, lo})) ? lo : (v > $signed({1'b0, hi})) ? hi : v[CW-1:0];
  endfunction
  // up is derived from the target delta: toward follows its sign, away inverts it
  function automatic logic step_up(input logic signed [CW:0] d, input logic away);
    return away ? d[CW] : !d[CW];
  endfunction
  function automatic logic [CW-1:0] step_axis(input logic [CW-1:0] p, input logic up, input logic [CW-1:0] s, input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    logic signed [CW:0] ps, ss;
    ps = $signed({1'b0, p});
    ss = $signed({1'b0, s});
    return clamp(up ? ps + ss : ps - ss, lo, hi);
  endfunction
endpackage

// File: rtl/ghost_unit.sv
// ghost_unit: one ghost's mode FSM, position, release counter and collision check.
module ghost_unit import ghost_pkg::*; #(
  parameter int IDX = 0,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int HOME_X = 200,
  parameter int HOME_Y = 146,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int STEP = 1,
  parameter int HIT_R = 8,
  parameter int RELEASE_TICKS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              f_on,
  input  logic              scatter,
  input  logic [X_W-1:0]    pac_x,
  input  logic [Y_W-1:0]    pac_y,
  output logic [X_W-1:0]    gx,
  output logic [Y_W-1:0]    gy,
  output logic [MODE_W-1:0] mode,
  output logic              hit_c,
  output logic              eaten
);
  localparam int REL = (IDX + 1) * RELEASE_TICKS;
  localparam int RW = $clog2(REL + 1);
  localparam logic signed [CW:0] HR = (CW + 1)'(HIT_R);
  localparam logic [X_W-1:0] CX = (IDX % 2 == 1) ? X_W'(X_MAX) : X_W'(X_MIN);
  localparam logic [Y_W-1:0] CY = (IDX % 4 >= 2) ? Y_W'(Y_MAX) : Y_W'(Y_MIN);
  logic [RW-1:0] rc;
  logic tog, col, mv, use_x, nz, rel, away;
  logic signed [CW:0] dx, dy, ax, ay, tdx, tdy, atx, aty;
  logic [X_W-1:0] tx, nx;
  logic [Y_W-1:0] ty, ny;
  logic [MODE_W-1:0] live;
  always_comb begin
    tx = mode == SCATTER ? CX : pac_x;
    ty = mode == SCATTER ? CY : pac_y;
    dx = $signed({1'b0, CW'(pac_x)}) - $signed({1'b0, CW'(gx)});
    dy = $signed({1'b0, CW'(pac_y)}) - $signed({1'b0, CW'(gy)});
    tdx = $signed({1'b0, CW'(tx)}) - $signed({1'b0, CW'(gx)});
    tdy = $signed({1'b0, CW'(ty)}) - $signed({1'b0, CW'(gy)});
    ax = dx[CW] ? -dx : dx;
    ay = dy[CW] ? -dy : dy;
    atx = tdx[CW] ? -tdx : tdx;
    aty = tdy[CW] ? -tdy : tdy;
    col = ax <= HR && ay <= HR;
    use_x = atx >= aty;
    nz = tdx != '0 || tdy != '0;
    away = mode == FRIGHT;
    mv = adv && nz && (mode == CHASE || mode == SCATTER || (mode == FRIGHT && tog));
    nx = (mv && use_x) ? X_W'(step_axis(CW'(gx), step_up(tdx, away), CW'(STEP), CW'(X_MIN), CW'(X_MAX))) : gx;
    ny = (mv && !use_x) ? Y_W'(step_axis(CW'(gy), step_up(tdy, away), CW'(STEP), CW'(Y_MIN), CW'(Y_MAX))) : gy;
    hit_c = adv && col && (mode == CHASE || mode == SCATTER);
    rel = rc == RW'(REL - 1);
    live = scatter ? SCATTER : CHASE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gx <= X_W'(HOME_X);
      gy <= Y_W'(HOME_Y);
      mode <= HOME;
      rc <= '0;
      tog <= 1'b0;
      eaten <= 1'b0;
    end else begin
      eaten <= adv && mode == FRIGHT && col;
      if (adv && mode == FRIGHT && col) begin
        gx <= X_W'(HOME_X);
        gy <= Y_W'(HOME_Y);
        mode <= HOME;
        rc <= '0;
        tog <= 1'b0;
      end else if (adv) begin
        gx <= nx;
        gy <= ny;
        tog <= mode == FRIGHT && !tog;
        rc <= mode == HOME ? rc + 1'b1 : '0;
        mode <= mode == HOME ? (rel ? (f_on ? FRIGHT : live) : HOME) : (f_on ? FRIGHT : live);
      end
    end
endmodule

// File: rtl/ghost_ctrl.sv
// ghost_ctrl: NUM_GHOSTS autonomous ghosts with staggered release, chase, timed fright and collisions.
// Define GHOST_SCATTER_EN to alternate CHASE/SCATTER phases every 256 ticks.
module ghost_ctrl import ghost_pkg::*; #(
  parameter int NUM_GHOSTS = 4,
  parameter int X_W = 10,
  parameter int Y_W = 9,
  parameter int HOME_X = 200,
  parameter int HOME_Y = 146,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int STEP = 1,
  parameter int HIT_R = 8,
  parameter int RELEASE_TICKS = 64,
  parameter int FRIGHT_TICKS = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         enable,
  input  logic                         frighten,
  input  logic [X_W-1:0]               pac_x,
  input  logic [Y_W-1:0]               pac_y,
  output logic [NUM_GHOSTS*X_W-1:0]    ghost_x,
  output logic [NUM_GHOSTS*Y_W-1:0]    ghost_y,
  output logic [NUM_GHOSTS*MODE_W-1:0] ghost_mode,
  output logic                         hit,
  output logic [NUM_GHOSTS-1:0]        eaten
);
  localparam int FW = $clog2(FRIGHT_TICKS + 1);
  logic adv, f_on, scatter;
  logic [FW-1:0] ft;
  logic [NUM_GHOSTS-1:0] hc;
  assign adv = tick && enable;
  // fright stays on for this tick unless the timer is about to hit zero
  assign f_on = (frighten && enable) || ft > FW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ft <= '0;
      hit <= 1'b0;
    end else begin
      hit <= |hc;
      if (enable && frighten) ft <= FW'(FRIGHT_TICKS);
      else if (adv && ft != '0) ft <= ft - 1'b1;
    end
`ifdef GHOST_SCATTER_EN
  logic [8:0] phase;
  always_ff @(posedge clk or negedge rst)
    if (!rst) phase <= '0;
    else if (adv) phase <= phase + 1'b1;
  assign scatter = phase[8];
`else
  assign scatter = 1'b0;
`endif
  for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_ghost
    ghost_unit #(
      .IDX(i), .X_W(X_W), .Y_W(Y_W), .HOME_X(HOME_X), .HOME_Y(HOME_Y),
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .STEP(STEP), .HIT_R(HIT_R), .RELEASE_TICKS(RELEASE_TICKS)
    ) u_ghost (
      .clk(clk), .rst(rst), .adv(adv), .f_on(f_on), .scatter(scatter),
      .pac_x(pac_x), .pac_y(pac_y),
      .gx(ghost_x[i*X_W +: X_W]), .gy(ghost_y[i*Y_W +: Y_W]),
      .mode(ghost_mode[i*MODE_W +: MODE_W]),
      .hit_c(hc[i]), .eaten(eaten[i])
    );
  end
endmodule

// File: tb/tb_ghost_ctrl.sv
// tb_ghost_ctrl: table-driven scenario walk through release, chase, fright, eat, clamp, enable and reset.
module tb_ghost_ctrl;
  localparam int NG = 4, XW = 10, YW = 9, NV = 30;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, enable = 1'b1, frighten = 1'b0;
  logic [XW-1:0] pac_x = '0;
  logic [YW-1:0] pac_y = '0;
  logic [NG*XW-1:0] ghost_x;
  logic [NG*YW-1:0] ghost_y;
  logic [NG*2-1:0] ghost_mode;
  logic hit;
  logic [NG-1:0] eaten;
  int checks = 0, failures = 0;
  typedef struct {
    int n; bit fs; bit ff; bit en; int px; int py;
    int sel; int ex; int ey; int em; int eh; int ee;
  } vec_t;
  vec_t tbl[NV];
  vec_t sb[$];
  always #5 clk = ~clk;
  ghost_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .frighten(frighten),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost_mode(ghost_mode), .hit(hit), .eaten(eaten)
  );
  function automatic vec_t mk(input int n, input bit fs, input bit ff, input bit en, input int px, input int py,
                              input int sel, input int ex, input int ey, input int em, input int eh, input int ee);
    vec_t v;
    v.n = n; v.fs = fs; v.ff = ff; v.en = en; v.px = px; v.py = py;
    v.sel = sel; v.ex = ex; v.ey = ey; v.em = em; v.eh = eh; v.ee = ee;
    return v;
  endfunction
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  // fs: frighten on its own idle cycle first; ff: frighten alongside the first tick
  task automatic drive(input int n, input bit fs, input bit ff, input bit en);
    if (fs) begin
      frighten = 1'b1;
      @(posedge clk); #1;
      frighten = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      enable = en;
      frighten = ff && k == 0;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    frighten = 1'b0;
    enable = 1'b1;
    if (n == 0) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    //             n    fs ff en  px   py  sel  ex   ey   mode  hit eaten
    tbl[0]  = mk(  0,   0, 0, 1, 210, 146, 0, 200, 146, 8'h00, 0, 0);
    tbl[1]  = mk( 63,   0, 0, 1, 210, 146, 0, 200, 146, 8'h00, 0, 0);
    tbl[2]  = mk(  1,   0, 0, 1, 210, 146, 0, 200, 146, 8'h01, 0, 0);
    tbl[3]  = mk(  1,   0, 0, 1, 210, 146, 0, 201, 146, 8'h01, 0, 0);
    tbl[4]  = mk(  1,   0, 0, 1, 210, 146, 0, 202, 146, 8'h01, 0, 0);
    tbl[5]  = mk(  1,   0, 0, 1, 210, 146, 0, 203, 146, 8'h01, 1, 0);
    tbl[6]  = mk(  7,   0, 0, 1, 210, 146, 0, 210, 146, 8'h01, 1, 0);
    tbl[7]  = mk(  0,   0, 0, 1, 210, 146, 0, 210, 146, 8'h01, 0, 0);
    tbl[8]  = mk(  1,   1, 0, 1, 260, 146, 0, 211, 146, 8'h02, 0, 0);
    tbl[9]  = mk( 52,   0, 0, 1, 260, 146, 0, 185, 146, 8'h02, 0, 0);
    tbl[10] = mk(  1,   0, 0, 1, 260, 146, 1, 200, 146, 8'h0A, 0, 0);
    tbl[11] = mk( 64,   0, 0, 1, 260, 146, 1, 168, 146, 8'h2A, 0, 0);
    tbl[12] = mk(  4,   0, 0, 1, 260, 146, 2, 198, 146, 8'h2A, 0, 0);
    tbl[13] = mk(  1,   0, 0, 1, 203, 146, 2, 200, 146, 8'h0A, 0, 4);
    tbl[14] = mk(  0,   0, 0, 1, 260, 146, 2, 200, 146, 8'h0A, 0, 0);
    tbl[15] = mk( 59,   0, 0, 1, 260, 146, 3, 200, 146, 8'h8A, 0, 0);
    tbl[16] = mk( 44,   0, 0, 1, 260, 146, 0,  99, 146, 8'h8A, 0, 0);
    tbl[17] = mk( 88,   1, 0, 1, 260, 146, 2, 200, 146, 8'h8A, 0, 0);
    tbl[18] = mk(  1,   0, 0, 1, 260, 146, 2, 200, 146, 8'hAA, 0, 0);
    tbl[19] = mk(197,   0, 0, 1, 260, 146, 0,   0, 146, 8'hAA, 0, 0);
    tbl[20] = mk(225,   0, 0, 1, 260, 146, 2,   0, 146, 8'hAA, 0, 0);
    tbl[21] = mk(  1,   0, 0, 1, 260, 146, 0,   0, 146, 8'h55, 0, 0);
    tbl[22] = mk(146,   0, 0, 1,   0,   0, 0,   0,   0, 8'h55, 1, 0);
    tbl[23] = mk(  2,   0, 0, 1,   0,   0, 3,   0,   0, 8'h55, 1, 0);
    tbl[24] = mk(  1,   0, 0, 1,  20,  20, 0,   1,   0, 8'h55, 0, 0);
    tbl[25] = mk(  1,   0, 1, 1,  20,  20, 0,   1,   1, 8'hAA, 0, 0);
    tbl[26] = mk(  1,   0, 0, 1,  20,  20, 0,   1,   1, 8'hAA, 0, 0);
    tbl[27] = mk(  1,   0, 0, 1,  20,  20, 0,   0,   1, 8'hAA, 0, 0);
    tbl[28] = mk(  2,   0, 0, 1,  20,  20, 0,   0,   1, 8'hAA, 0, 0);
    tbl[29] = mk(100,   0, 0, 0,  20,  20, 1,   0,   1, 8'hAA, 0, 0);
    pac_x = 10'd210;
    pac_y = 9'd146;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NV; i++) begin
      pac_x = XW'(tbl[i].px);
      pac_y = YW'(tbl[i].py);
      sb.push_back(tbl[i]);
      drive(tbl[i].n, tbl[i].fs, tbl[i].ff, tbl[i].en);
      v = sb.pop_front();
      check($sformatf("v%0d.x", i), int'(ghost_x[v.sel*XW +: XW]), v.ex);
      check($sformatf("v%0d.y", i), int'(ghost_y[v.sel*YW +: YW]), v.ey);
      check($sformatf("v%0d.mode", i), int'(ghost_mode), v.em);
      check($sformatf("v%0d.hit", i), int'(hit), v.eh);
      check($sformatf("v%0d.eaten", i), int'(eaten), v.ee);
    end
    // asynchronous reset between clock edges while every ghost is frightened
    rst = 1'b0;
    #2;
    check("arst.mode", int'(ghost_mode), 0);
    check("arst.hit", int'(hit), 0);
    for (int g = 0; g < NG; g++) begin
      check($sformatf("arst.x%0d", g), int'(ghost_x[g*XW +: XW]), 200);
      check($sformatf("arst.y%0d", g), int'(ghost_y[g*YW +: YW]), 146);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pac_x = 10'd400;
    pac_y = 9'd300;
    drive(63, 1'b0, 1'b0, 1'b1);
    check("post_rst.home", int'(ghost_mode), 0);
    drive(1, 1'b0, 1'b0, 1'b1);
    check("post_rst.release", int'(ghost_mode), 1);
    drive(1, 1'b0, 1'b0, 1'b1);
    check("post_rst.x0", int'(ghost_x[0 +: XW]), 201);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
